div_core_seq: RTL
=================

# div_core_seq

Sequential radix-2 restoring divider between the input packer (`fifo_top_in`, 65-bit operand word plus `valid_o`) and the output unpacker (`fifo_out_top`, 65-bit result word plus `valid_i`). It accepts one packed operand word, iterates one quotient bit per cycle, and presents a packed 65-bit quotient/remainder/flag word under a valid/ready handshake. Only one division is in flight at a time.

## Interface
- `OP_WIDTH`, 32, operand width in bits; dividend and divisor are each `OP_WIDTH`.
- `DATA_WIDTH`, 65, packed word width; must equal 2*`OP_WIDTH`+1.
- `CNT_WIDTH`, 6, iteration counter width; must be ≥ clog2(`OP_WIDTH`+1).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `valid_i`  in  1  operand word valid (driven from packer `valid_o`).
- `ready_o`  out  1  block can accept an operand word.
- `data_i`  in  `DATA_WIDTH`  [64] signed-mode flag, [63:32] dividend, [31:0] divisor.
- `valid_o`  out  1  result word valid (drives unpacker `valid_i`).
- `ready_i`  in  1  downstream accepts result.
- `data_o`  out  `DATA_WIDTH`  [64] divide-by-zero flag, [63:32] quotient, [31:0] remainder.
- `busy_o`  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE. Reset: IDLE, `ready_o`=1, `valid_o`=0, `busy_o`=0, `data_o`=0, counter=0.
- IDLE: `ready_o`=1. On `valid_i`&&`ready_o`: latch signed flag and operands.
  - Divisor ≠ 0: go to CALC, counter=0.
  - Divisor = 0: go to DONE directly.
- Signed mode: operands are two's complement; divide magnitudes. Quotient sign = sign(dividend) XOR sign(divisor). Remainder sign = sign(dividend). Unsigned mode: no conversion.
- CALC: each cycle shift {rem,quo} left one bit, trial-subtract the divisor magnitude, and keep the result when non-negative (quotient bit = 1). The remainder register is `OP_WIDTH`+1 bits wide. Counter increments each cycle; on the cycle where counter = `OP_WIDTH`-1, write the sign-corrected result to `data_o` and go to DONE.
- Divide by zero: `data_o` = {1'b1, all-ones quotient, dividend unchanged}, in both signed and unsigned mode.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0, flag 0. This falls out of the normal datapath with 32-bit truncation; no special case.
- DONE: `valid_o`=1, and `data_o` is stable until handshake. On `ready_i`: `valid_o`→0 and the block returns to IDLE. While `ready_i`=0, hold indefinitely.
- `ready_o`=0 in CALC and DONE. A `valid_i` arriving then is ignored; the upstream holds its word.

## Timing
- Accept edge = T0.
- Normal division: CALC occupies edges T0+1..T0+`OP_WIDTH`. `valid_o` is high after edge T0+`OP_WIDTH` (32 cycles from accept).
- Divide by zero: `valid_o` is high after edge T0+1.
- Result handshake edge Tr (`valid_o`&&`ready_i`): `ready_o`=1 after Tr. The next accept is no earlier than edge Tr+1, so throughput is at most 1 op per `OP_WIDTH`+2 cycles.
- `data_o` changes only on the edge entering DONE and on reset; it is not cleared on leaving DONE.
- `rst_n`=0 at any edge, including mid-CALC or in DONE with `valid_o` high: the in-flight op is discarded, all outputs take reset values on that edge, and no partial result is emitted.
- `ready_i` high outside DONE has no effect.

## Test plan
- Unsigned 100/7 (data_i = {0,0x00000064,0x00000007}) -> `valid_o` 32 cycles after accept, `data_o`={0,0x0000000E,0x00000002}.
- Signed -7/2 ({1,0xFFFFFFF9,0x00000002}) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, flag 0. Signed 0x80000000/0xFFFFFFFF -> {0,0x80000000,0x00000000}.
- Divide by zero ({1,0x00001234,0}) -> `valid_o` one cycle after accept, `data_o`={1,0xFFFFFFFF,0x00001234}.
- Backpressure: hold `ready_i`=0 for 10 cycles in DONE -> `valid_o`/`data_o` stable and `ready_o`=0. A second `valid_i` word is not accepted until one cycle after the handshake, then completes correctly.
- Reset mid-operation: assert `rst_n`=0 at CALC iteration 15 -> next edge `valid_o`=0, `ready_o`=1, `data_o`=0. A subsequent 0xFFFFFFFF/1 unsigned -> {0,0xFFFFFFFF,0}.
- Random sweep, 10k ops, both modes, random `ready_i` gaps -> every result matches a reference model (truncating division, remainder sign follows dividend), one result per accepted word, order preserved.

Source files
------------

// File: rtl/div_core_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// master = upstream packer / downstream unpacker side, slave = divider.
interface div_core_seq_if #(
  parameter int unsigned DATA_WIDTH = 65
);
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  busy_o;

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, busy_o
  );

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, busy_o
  );
endinterface

// File: rtl/div_core_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle.
// Accepts {signed, dividend, divisor}, returns {div_by_zero, quotient, remainder}.
module div_core_seq #(
  parameter int unsigned OP_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 65,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input logic           clk,
  input logic           rst_n,
  div_core_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(OP_WIDTH - 1);

  logic [1:0]            state_q,    state_d;
  logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;
  logic [OP_WIDTH:0]     rem_q,      rem_d;
  logic [OP_WIDTH-1:0]   quo_q,      quo_d;
  logic [OP_WIDTH-1:0]   dvsr_q,     dvsr_d;
  logic [OP_WIDTH-1:0]   dvnd_q,     dvnd_d;
  logic                  neg_quo_q,  neg_quo_d;
  logic                  neg_rem_q,  neg_rem_d;
  logic                  dz_q,       dz_d;
  logic                  ready_q,    ready_d;
  logic                  valid_q,    valid_d;
  logic                  busy_q,     busy_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;

  logic                  op_sgn;
  logic [OP_WIDTH-1:0]   op_a;
  logic [OP_WIDTH-1:0]   op_b;
  logic [OP_WIDTH-1:0]   a_mag;
  logic [OP_WIDTH-1:0]   b_mag;
  logic [OP_WIDTH:0]     shifted;
  logic [OP_WIDTH:0]     trial;
  logic                  quo_bit;
  logic [OP_WIDTH:0]     rem_step;
  logic [OP_WIDTH-1:0]   quo_step;
  logic [OP_WIDTH-1:0]   rem_low;
  logic [OP_WIDTH-1:0]   quo_fix;
  logic [OP_WIDTH-1:0]   rem_fix;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      dvnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      dvnd_q    <= dvnd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
    end
  end

  // Next-state, iteration step and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    dvnd_d    = dvnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    data_d    = data_q;

    op_sgn = bus.data_i[2*OP_WIDTH];
    op_a   = bus.data_i[2*OP_WIDTH-1:OP_WIDTH];
    op_b   = bus.data_i[OP_WIDTH-1:0];
    a_mag  = (op_sgn && op_a[OP_WIDTH-1]) ? -op_a : op_a;
    b_mag  = (op_sgn && op_b[OP_WIDTH-1]) ? -op_b : op_b;

    // Remainder stays below the divisor, so OP_WIDTH+1 bits hold the shifted value
    shifted  = {rem_q[OP_WIDTH-1:0], quo_q[OP_WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    quo_bit  = ~trial[OP_WIDTH];
    rem_step = quo_bit ? trial : shifted;
    quo_step = {quo_q[OP_WIDTH-2:0], quo_bit};
    rem_low  = rem_step[OP_WIDTH-1:0];
    quo_fix  = neg_quo_q ? -quo_step : quo_step;
    rem_fix  = neg_rem_q ? -rem_low : rem_low;

    case (state_q)
      IDLE: begin
        if (bus.valid_i && ready_q) begin
          dvnd_d    = op_a;
          dvsr_d    = b_mag;
          quo_d     = a_mag;
          rem_d     = '0;
          neg_quo_d = op_sgn & (op_a[OP_WIDTH-1] ^ op_b[OP_WIDTH-1]);
          neg_rem_d = op_sgn & op_a[OP_WIDTH-1];
          dz_d      = (op_b == '0);
          // Zero divisor makes a single pass so its flagged result lands one edge after accept
          cnt_d     = (op_b == '0) ? LAST_CNT : '0;
          state_d   = CALC;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          valid_d = 1'b1;
          data_d  = dz_q ? {1'b1, {OP_WIDTH{1'b1}}, dvnd_q}
                         : {1'b0, quo_fix, rem_fix};
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.data_o  = data_q;

endmodule
